// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes in MEM,
// data-memory wait freeze with sticky timeout error, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             pc_sel_branch,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MWAIT, MERR} state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

  state_t           state_reg, state_next;
  logic [7:0]       wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  logic freeze, taken, lduse;
  logic stall_inc, flush_inc;

  assign freeze = mem_access & ~dmem_ready;
  assign taken  = mem_branch & mem_zero;
  assign lduse  = ex_mem_read & (ex_rd != 5'd0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // Output priority: reset > MERR > freeze > taken > lduse > normal.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    pc_sel_branch = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    if (rst || state_reg == MERR) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (freeze) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      stall_inc    = 1'b1;
    end else if (taken) begin
      pc_sel_branch = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_flush  = 1'b1;
      flush_inc     = 1'b1;
    end else if (lduse) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      stall_inc   = 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      RUN: begin
        if (freeze) begin
          state_next    = MWAIT;
          wait_cnt_next = 8'd1;
        end
      end
      MWAIT: begin
        if (!mem_access || dmem_ready) begin
          state_next    = RUN;
          wait_cnt_next = 8'd0;
        end else if (wait_cnt_reg + 8'd1 == TIMEOUT_LIM) begin
          state_next = MERR;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      default: state_next = MERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= 8'd0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      // Counters saturate at all-ones rather than wrapping.
      if (stall_inc && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (flush_inc && flush_cnt_reg != '1)
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign mem_err   = (state_reg == MERR);
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default instance (TIMEOUT=16, CNT_W=16)
// and a small instance (TIMEOUT=4, CNT_W=4) share the same stimulus.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read, mem_branch, mem_zero, mem_access, dmem_ready;

  logic a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en;
  logic a_if_id_flush, a_id_ex_flush, a_ex_mem_flush, a_mem_wb_flush, a_pc_sel, a_mem_err;
  logic [15:0] a_stall, a_flush;
  logic b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en;
  logic b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_mem_wb_flush, b_pc_sel, b_mem_err;
  logic [3:0] b_stall, b_flush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(a_pc_en), .if_id_en(a_if_id_en), .id_ex_en(a_id_ex_en),
    .ex_mem_en(a_ex_mem_en), .mem_wb_en(a_mem_wb_en),
    .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush),
    .ex_mem_flush(a_ex_mem_flush), .mem_wb_flush(a_mem_wb_flush),
    .pc_sel_branch(a_pc_sel), .mem_err(a_mem_err),
    .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(b_pc_en), .if_id_en(b_if_id_en), .id_ex_en(b_id_ex_en),
    .ex_mem_en(b_ex_mem_en), .mem_wb_en(b_mem_wb_en),
    .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush),
    .ex_mem_flush(b_ex_mem_flush), .mem_wb_flush(b_mem_wb_flush),
    .pc_sel_branch(b_pc_sel), .mem_err(b_mem_err),
    .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  // Control word: {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem,mem_wb flushes, pc_sel}
  logic [9:0] ctl_a, ctl_b;
  assign ctl_a = {a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en,
                  a_if_id_flush, a_id_ex_flush, a_ex_mem_flush, a_mem_wb_flush, a_pc_sel};
  assign ctl_b = {b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en,
                  b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_mem_wb_flush, b_pc_sel};

  localparam logic [9:0] C_NORMAL = 10'b11111_0000_0;
  localparam logic [9:0] C_OFF    = 10'b00000_0000_0;
  localparam logic [9:0] C_FREEZE = 10'b00001_0001_0;
  localparam logic [9:0] C_TAKEN  = 10'b11111_1110_1;
  localparam logic [9:0] C_LDUSE  = 10'b00111_0100_0;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, mrd, br, zr, acc, rdy;
    logic [9:0] ctl;
    int         sinc, finc;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int exp_stall, exp_flush;
  vec_t vecs[12];

  function automatic vec_t mk(string name, logic [4:0] rs1, logic [4:0] rs2, logic use1,
                              logic use2, logic mrd, logic [4:0] rd, logic br, logic zr,
                              logic acc, logic rdy, logic [9:0] ctl, int sinc, int finc);
    vec_t v;
    v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2; v.mrd = mrd;
    v.rd = rd; v.br = br; v.zr = zr; v.acc = acc; v.rdy = rdy; v.ctl = ctl;
    v.sinc = sinc; v.finc = finc;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic [4:0] rs1, logic [4:0] rs2, logic use1, logic use2, logic mrd,
                       logic [4:0] rd, logic br, logic zr, logic acc, logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = use1; id_use_rs2 = use2;
    ex_mem_read = mrd; ex_rd = rd; mem_branch = br; mem_zero = zr;
    mem_access = acc; dmem_ready = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    vecs[0]  = mk("normal",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORMAL, 0, 0);
    vecs[1]  = mk("lduse_rs1",      5, 0, 1, 0, 1, 5, 0, 0, 0, 0, C_LDUSE,  1, 0);
    vecs[2]  = mk("lduse_rd0",      0, 0, 1, 1, 1, 0, 0, 0, 0, 0, C_NORMAL, 0, 0);
    vecs[3]  = mk("lduse_rs2",      1, 7, 0, 1, 1, 7, 0, 0, 0, 0, C_LDUSE,  1, 0);
    vecs[4]  = mk("rs2_unused",     1, 7, 1, 0, 1, 7, 0, 0, 0, 0, C_NORMAL, 0, 0);
    vecs[5]  = mk("no_load",        7, 7, 1, 1, 0, 7, 0, 0, 0, 0, C_NORMAL, 0, 0);
    vecs[6]  = mk("taken_over_ld",  5, 0, 1, 0, 1, 5, 1, 1, 0, 0, C_TAKEN,  0, 1);
    vecs[7]  = mk("branch_nz",      0, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_NORMAL, 0, 0);
    vecs[8]  = mk("zero_nobr",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_NORMAL, 0, 0);
    vecs[9]  = mk("freeze_over_all",5, 0, 1, 0, 1, 5, 1, 1, 1, 0, C_FREEZE, 1, 0);
    vecs[10] = mk("release_lduse",  5, 0, 1, 0, 1, 5, 0, 0, 1, 1, C_LDUSE,  1, 0);
    vecs[11] = mk("access_ready",   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NORMAL, 0, 0);

    // Reset state: outputs forced off while rst=1, counters cleared.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ctl_forced", 32'(ctl_a), 32'(C_OFF));
    chk("rst_stall", 32'(a_stall), 0);
    chk("rst_flush", 32'(a_flush), 0);
    chk("rst_mem_err", 32'(a_mem_err), 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single-cycle vectors.
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].use1, vecs[i].use2, vecs[i].mrd, vecs[i].rd,
            vecs[i].br, vecs[i].zr, vecs[i].acc, vecs[i].rdy);
      #1;
      chk({vecs[i].name, "_ctl"}, 32'(ctl_a), 32'(vecs[i].ctl));
      exp_stall += vecs[i].sinc;
      exp_flush += vecs[i].finc;
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_stall_cnt"}, 32'(a_stall), 32'(exp_stall));
      chk({vecs[i].name, "_flush_cnt"}, 32'(a_flush), 32'(exp_flush));
    end

    // Memory wait: 3 frozen cycles then release on the 4th.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      chk($sformatf("mwait_freeze%0d", i), 32'(ctl_a), 32'(C_FREEZE));
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    #1;
    chk("mwait_release", 32'(ctl_a), 32'(C_NORMAL));
    @(negedge clk);
    idle();
    #1;
    chk("mwait_after", 32'(ctl_a), 32'(C_NORMAL));
    chk("mwait_stall_cnt", 32'(a_stall), 3);
    chk("mwait_no_err", 32'(a_mem_err), 0);

    // Timeout on the small instance: exactly 4 frozen cycles, then sticky MERR.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      chk($sformatf("tmo_freeze%0d", i), 32'(ctl_b), 32'(C_FREEZE));
      chk($sformatf("tmo_err_low%0d", i), 32'(b_mem_err), 0);
    end
    @(negedge clk);
    #1;
    chk("tmo_merr_ctl", 32'(ctl_b), 32'(C_OFF));
    chk("tmo_merr_flag", 32'(b_mem_err), 1);
    chk("tmo_a_still_freeze", 32'(ctl_a), 32'(C_FREEZE));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      dmem_ready = 1'b1;
      mem_branch = 1'b1;
      mem_zero = 1'b1;
      #1;
      chk($sformatf("tmo_sticky_ctl%0d", i), 32'(ctl_b), 32'(C_OFF));
      chk($sformatf("tmo_sticky_err%0d", i), 32'(b_mem_err), 1);
    end
    chk("tmo_stall_frozen", 32'(b_stall), 4);
    chk("tmo_flush_frozen", 32'(b_flush), 0);
    do_reset();
    #1;
    chk("tmo_rst_err", 32'(b_mem_err), 0);
    chk("tmo_rst_stall", 32'(b_stall), 0);
    chk("tmo_rst_ctl", 32'(ctl_b), 32'(C_NORMAL));

    // Saturation: 20 load-use cycles on a 4-bit counter.
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      drive(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("sat_b_%0d", i), 32'(b_stall), (i > 15) ? 15 : i);
    end
    chk("sat_a_20", 32'(a_stall), 20);

    // Reset during the 2nd MWAIT cycle.
    do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    #1;
    chk("midrst_in_wait", 32'(ctl_a), 32'(C_FREEZE));
    rst = 1'b1;
    #1;
    chk("midrst_forced", 32'(ctl_a), 32'(C_OFF));
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("midrst_normal", 32'(ctl_a), 32'(C_NORMAL));
    chk("midrst_stall", 32'(a_stall), 0);
    chk("midrst_flush", 32'(a_flush), 0);
    // wait_cnt must restart: small instance again needs 4 frozen cycles.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      chk($sformatf("midrst_b_freeze%0d", i), 32'(ctl_b), 32'(C_FREEZE));
    end
    @(negedge clk);
    #1;
    chk("midrst_b_merr", 32'(b_mem_err), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
